// File: rtl/ternary_pkg.sv
// Shared types and constants for the ternary sampling path.
package ternary_pkg;

  localparam int N_HRSS   = 701;
  localparam int NIBBLE_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } ser_state_t;

endpackage

// File: rtl/mux_i4_o1.sv
// 4:1 bit-select mux: picks one bit of a nibble by a 2-bit index.
module mux_i4_o1
  import ternary_pkg::*;
(
  input  logic [NIBBLE_W-1:0] a,
  input  logic [1:0]          sel,
  output logic                y
);

  assign y = a[sel];

endmodule

// File: rtl/ternary_nibble_serializer.sv
// Buffers up to two nibbles and emits them LSB first, one bit per cycle,
// framing NUM_NIBBLES nibbles per polynomial with last/done markers.
module ternary_nibble_serializer
  import ternary_pkg::*;
#(
  parameter  int NUM_NIBBLES = 176,
  localparam int CNT_W       = $clog2(NUM_NIBBLES + 1)
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [3:0] in_nibble,
  output logic       out_valid,
  input  logic       out_ready,
  output logic       out_bit,
  output logic [1:0] out_sel,
  output logic       out_last,
  output logic       done,
  output logic       busy
);

  localparam logic [CNT_W-1:0] ACC_MAX  = CNT_W'(NUM_NIBBLES);
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(NUM_NIBBLES - 1);

  ser_state_t            state, state_nxt;
  logic [NIBBLE_W-1:0]   head, spare;
  logic                  head_full, spare_full;
  logic [1:0]            sel;
  logic [CNT_W-1:0]      acc_cnt, emit_cnt;
  logic                  accept, xfer, retire, mux_bit;

  assign in_ready  = (state == RUN) && !spare_full && (acc_cnt < ACC_MAX);
  assign accept    = in_valid & in_ready;
  assign out_valid = head_full;
  assign xfer      = out_valid & out_ready;
  assign retire    = xfer & (sel == 2'd3);
  assign out_last  = out_valid & (sel == 2'd3) & (emit_cnt == LAST_IDX);
  assign out_sel   = sel;
  assign out_bit   = mux_bit;

  mux_i4_o1 u_mux (
    .a   (head),
    .sel (sel),
    .y   (mux_bit)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    done      = 1'b0;
    busy      = 1'b1;
    case (state)
      IDLE: begin
        busy = 1'b0;
        if (start) state_nxt = RUN;
      end
      RUN: begin
        if (xfer && out_last) state_nxt = DONE;
      end
      DONE: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Head always feeds the mux; spare only fills while head is occupied.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head       <= '0;
      spare      <= '0;
      head_full  <= 1'b0;
      spare_full <= 1'b0;
      sel        <= 2'd0;
      acc_cnt    <= '0;
      emit_cnt   <= '0;
    end else if (state == IDLE) begin
      if (start) begin
        head_full  <= 1'b0;
        spare_full <= 1'b0;
        sel        <= 2'd0;
        acc_cnt    <= '0;
        emit_cnt   <= '0;
      end
    end else if (state == RUN) begin
      if (accept) acc_cnt <= acc_cnt + CNT_W'(1);
      if (xfer)   sel     <= sel + 2'd1;
      if (retire) emit_cnt <= emit_cnt + CNT_W'(1);

      if (accept && !head_full) begin
        head      <= in_nibble;
        head_full <= 1'b1;
      end else if (retire) begin
        // in_ready excludes a full spare, so accept and spare refill never collide.
        if (spare_full) begin
          head       <= spare;
          spare_full <= 1'b0;
        end else if (accept) begin
          head <= in_nibble;
        end else begin
          head_full <= 1'b0;
        end
      end else if (accept) begin
        spare      <= in_nibble;
        spare_full <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_ternary_nibble_serializer.sv
// Randomized bench for ternary_nibble_serializer against a bit-queue model.
module tb_ternary_nibble_serializer;

  localparam int NN = 2;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic       in_valid;
  logic       in_ready;
  logic [3:0] in_nibble;
  logic       out_valid;
  logic       out_ready;
  logic       out_bit;
  logic [1:0] out_sel;
  logic       out_last;
  logic       done;
  logic       busy;

  int         n_vec = 0;
  int         n_err = 0;
  logic [3:0] offer [0:7];
  logic [7:0] got_bits;
  int         last_acc;

  ternary_nibble_serializer #(.NUM_NIBBLES(NN)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_nibble (in_nibble),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_bit   (out_bit),
    .out_sel   (out_sel),
    .out_last  (out_last),
    .done      (done),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; start = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_nibble = 4'h0;
    repeat (2) @(posedge clk);
    #3;
    rst = 1'b0;
    step();
  endtask

  // Model: accepted nibbles become a queue of bits, LSB first; every transfer pops one.
  task automatic run_poly(input int n_offer, input int vprob, input int rprob,
                          input int start_at, input string tag);
    bit exp_q[$];
    int oi, bi, acc;
    bit fin, sp;
    oi = 0; bi = 0; acc = 0; fin = 0; sp = 0;
    start = 1'b1;
    step();
    start = 1'b0;
    n_vec++;
    if (busy !== 1'b1) begin n_err++; $display("FAIL %s busy_after_start got=%b exp=1", tag, busy); end
    for (int cyc = 0; cyc < 400 && !fin; cyc++) begin
      n_vec++;
      if (out_valid !== (exp_q.size() > 0)) begin
        n_err++; $display("FAIL %s out_valid got=%b exp=%0d", tag, out_valid, exp_q.size() > 0);
      end
      n_vec++;
      if (out_last !== (out_valid && bi == 4*NN-1)) begin
        n_err++; $display("FAIL %s out_last got=%b bit_idx=%0d", tag, out_last, bi);
      end
      n_vec++;
      if (done !== 1'b0) begin n_err++; $display("FAIL %s done_early got=%b exp=0", tag, done); end
      if (acc >= NN) begin
        n_vec++;
        if (in_ready !== 1'b0) begin n_err++; $display("FAIL %s in_ready_sat got=%b exp=0", tag, in_ready); end
      end
      in_valid  = (oi < n_offer) && ($urandom_range(99) < vprob);
      in_nibble = (oi < n_offer) ? offer[oi] : 4'($urandom);
      out_ready = ($urandom_range(99) < rprob);
      start     = 1'b0;
      if (start_at >= 0 && !sp && out_valid && bi == start_at) begin start = 1'b1; sp = 1; end
      if (out_valid && out_ready && exp_q.size() > 0) begin
        n_vec++;
        if (out_bit !== exp_q[0] || out_sel !== 2'(bi % 4)) begin
          n_err++;
          $display("FAIL %s bit%0d got bit=%b sel=%0d exp bit=%b sel=%0d",
                   tag, bi, out_bit, out_sel, exp_q[0], bi % 4);
        end
        if (bi < 8) got_bits[bi] = out_bit;
        void'(exp_q.pop_front());
        bi++;
      end
      if (in_valid && in_ready) begin
        for (int k = 0; k < 4; k++) exp_q.push_back(offer[oi][k]);
        oi++; acc++;
      end
      step();
      if (bi == 4*NN) begin
        start = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        n_vec++;
        if (done !== 1'b1 || busy !== 1'b1) begin
          n_err++; $display("FAIL %s done_pulse got done=%b busy=%b exp 1/1", tag, done, busy);
        end
        step();
        n_vec++;
        if (done !== 1'b0 || busy !== 1'b0 || out_valid !== 1'b0) begin
          n_err++;
          $display("FAIL %s idle_after_done got done=%b busy=%b out_valid=%b exp 0/0/0", tag, done, busy, out_valid);
        end
        fin = 1;
      end
    end
    if (!fin) begin
      n_vec++; n_err++;
      $display("FAIL %s timeout bits=%0d exp=%0d", tag, bi, 4*NN);
    end
    last_acc = oi;
    start = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    n_vec++;
    if ({in_ready, out_valid, out_bit, out_sel, out_last, done, busy} !== 8'h00) begin
      n_err++;
      $display("FAIL reset_outputs got=%b exp=00000000",
               {in_ready, out_valid, out_bit, out_sel, out_last, done, busy});
    end
    in_valid = 1'b1; in_nibble = 4'hF;
    for (int i = 0; i < 3; i++) begin
      step();
      n_vec++;
      if (in_ready !== 1'b0 || out_valid !== 1'b0 || busy !== 1'b0) begin
        n_err++;
        $display("FAIL idle_no_start got in_ready=%b out_valid=%b busy=%b exp 0/0/0", in_ready, out_valid, busy);
      end
    end
    in_valid = 1'b0;
  endtask

  task automatic test_basic();
    offer[0] = 4'hA; offer[1] = 4'h3; got_bits = '0;
    run_poly(2, 100, 100, -1, "basic");
    n_vec++;
    if (got_bits !== 8'h3A) begin n_err++; $display("FAIL basic_stream got=%h exp=3a", got_bits); end
  endtask

  task automatic test_last_done();
    offer[0] = 4'hF; offer[1] = 4'h1; got_bits = '0;
    run_poly(2, 100, 100, -1, "last_done");
    n_vec++;
    if (got_bits !== 8'h1F) begin n_err++; $display("FAIL last_done_stream got=%h exp=1f", got_bits); end
  endtask

  task automatic test_backpressure();
    logic [7:0] exp_bits;
    exp_bits = 8'h96;
    start = 1'b1; step(); start = 1'b0;
    in_valid = 1'b1; in_nibble = 4'h6; out_ready = 1'b0;
    n_vec++;
    if (in_ready !== 1'b1) begin n_err++; $display("FAIL bp_ready_first got=%b exp=1", in_ready); end
    step();
    n_vec++;
    if (out_valid !== 1'b1 || out_sel !== 2'd0 || out_bit !== 1'b0) begin
      n_err++; $display("FAIL bp_latency got valid=%b sel=%0d bit=%b exp 1/0/0", out_valid, out_sel, out_bit);
    end
    in_nibble = 4'h9;
    n_vec++;
    if (in_ready !== 1'b1) begin n_err++; $display("FAIL bp_spare_ready got=%b exp=1", in_ready); end
    step();
    in_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      n_vec++;
      if (out_valid !== 1'b1 || out_bit !== 1'b0 || out_sel !== 2'd0 || in_ready !== 1'b0) begin
        n_err++;
        $display("FAIL bp_hold%0d got valid=%b bit=%b sel=%0d in_ready=%b exp 1/0/0/0",
                 i, out_valid, out_bit, out_sel, in_ready);
      end
      step();
    end
    out_ready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      n_vec++;
      if (out_valid !== 1'b1 || out_bit !== exp_bits[k] || out_sel !== 2'(k % 4)) begin
        n_err++;
        $display("FAIL bp_drain%0d got valid=%b bit=%b sel=%0d exp 1/%b/%0d",
                 k, out_valid, out_bit, out_sel, exp_bits[k], k % 4);
      end
      step();
    end
    out_ready = 1'b0;
    n_vec++;
    if (done !== 1'b1) begin n_err++; $display("FAIL bp_done got=%b exp=1", done); end
    step();
    n_vec++;
    if (busy !== 1'b0) begin n_err++; $display("FAIL bp_idle got busy=%b exp=0", busy); end
  endtask

  task automatic test_oversupply();
    offer[0] = 4'h5; offer[1] = 4'h9; offer[2] = 4'hE;
    run_poly(3, 100, 50, -1, "oversupply");
    n_vec++;
    if (last_acc != NN) begin n_err++; $display("FAIL oversupply_accepts got=%0d exp=%0d", last_acc, NN); end
  endtask

  task automatic test_start_ignored();
    offer[0] = 4'($urandom); offer[1] = 4'($urandom); got_bits = '0;
    run_poly(2, 100, 100, 3, "start_ignored");
    n_vec++;
    if (got_bits !== {offer[1], offer[0]}) begin
      n_err++; $display("FAIL start_ignored_stream got=%h exp=%h", got_bits, {offer[1], offer[0]});
    end
  endtask

  task automatic test_async_reset();
    start = 1'b1; step(); start = 1'b0;
    in_valid = 1'b1; in_nibble = 4'h5; out_ready = 1'b1;
    step();
    in_valid = 1'b0;
    step(); step();
    n_vec++;
    if (out_sel !== 2'd2 || out_valid !== 1'b1) begin
      n_err++; $display("FAIL arst_setup got sel=%0d valid=%b exp 2/1", out_sel, out_valid);
    end
    #2 rst = 1'b1;
    #1;
    n_vec++;
    if (out_valid !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b0 || out_sel !== 2'd0 || done !== 1'b0) begin
      n_err++;
      $display("FAIL arst_immediate got valid=%b busy=%b in_ready=%b sel=%0d done=%b exp all 0",
               out_valid, busy, in_ready, out_sel, done);
    end
    #2 rst = 1'b0;
    out_ready = 1'b0;
    step();
    n_vec++;
    if (out_valid !== 1'b0 || done !== 1'b0) begin
      n_err++; $display("FAIL arst_release got valid=%b done=%b exp 0/0", out_valid, done);
    end
    offer[0] = 4'hC; offer[1] = 4'($urandom); got_bits = '0;
    run_poly(2, 100, 100, -1, "after_arst");
    n_vec++;
    if (got_bits[3:0] !== 4'hC) begin n_err++; $display("FAIL arst_fresh got=%h exp=c", got_bits[3:0]); end
  endtask

  task automatic test_random();
    for (int it = 0; it < 20; it++) begin
      for (int j = 0; j < 3; j++) offer[j] = 4'($urandom);
      run_poly(($urandom_range(1) == 0) ? 2 : 3,
               int'($urandom_range(100, 30)), int'($urandom_range(100, 30)),
               int'($urandom_range(8)) - 1, "random");
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_last_done();
    test_backpressure();
    test_oversupply();
    test_start_ignored();
    test_async_reset();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
